// File: rtl/axi_cmd_master.sv
// Single-outstanding AXI4 initiator: one command in, one single-beat 32-bit
// AXI write or read out, one response back, with a watchdog abort per transaction.
package axi_cmd_pkg;

  localparam int AXI_ID_W = 4;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  typedef struct packed {
    logic [AXI_ID_W-1:0] awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic                awvalid;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                bready;
    logic [AXI_ID_W-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic                arvalid;
    logic                rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                awready;
    logic                wready;
    logic [AXI_ID_W-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                arready;
    logic [AXI_ID_W-1:0] rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
  } s_axi_miso_t;

endpackage

module axi_cmd_master
  import axi_cmd_pkg::*;
#(
  parameter logic [AXI_ID_W-1:0] AXI_ID         = '0,
  parameter int unsigned         TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_wstrb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        busy_o,
  output s_axi_mosi_t axi_mosi,
  input  s_axi_miso_t axi_miso
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RSP
  } state_t;

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_reg;
  s_axi_mosi_t mosi_reg;
  logic        aw_sent_reg;
  logic        w_sent_reg;
  logic [15:0] wdog_reg;
  logic        cmd_ready_reg;
  logic        busy_reg;
  logic        rsp_valid_reg;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_err_reg;
  logic        rsp_timeout_reg;

  logic aw_hs;
  logic w_hs;
  logic aw_done;
  logic w_done;
  logic b_hs;
  logic b_err;
  logic ar_hs;
  logic r_hs;
  logic r_err;
  logic wdog_expired;

  // Handshake decode feeds only the next-state logic; every output is a flop.
  always_comb begin
    aw_hs        = mosi_reg.awvalid && axi_miso.awready;
    w_hs         = mosi_reg.wvalid && axi_miso.wready;
    aw_done      = aw_sent_reg || aw_hs;
    w_done       = w_sent_reg || w_hs;
    b_hs         = mosi_reg.bready && axi_miso.bvalid;
    b_err        = (axi_miso.bresp != AXI_RESP_OKAY) || (axi_miso.bid != AXI_ID);
    ar_hs        = mosi_reg.arvalid && axi_miso.arready;
    r_hs         = mosi_reg.rready && axi_miso.rvalid;
    r_err        = (axi_miso.rresp != AXI_RESP_OKAY) || (axi_miso.rid != AXI_ID) ||
                   !axi_miso.rlast;
    wdog_expired = (wdog_reg == WDOG_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      mosi_reg        <= '0;
      aw_sent_reg     <= 1'b0;
      w_sent_reg      <= 1'b0;
      wdog_reg        <= '0;
      cmd_ready_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_reg) begin
            cmd_ready_reg    <= 1'b0;
            busy_reg         <= 1'b1;
            wdog_reg         <= '0;
            aw_sent_reg      <= 1'b0;
            w_sent_reg       <= 1'b0;
            rsp_rdata_reg    <= '0;
            rsp_err_reg      <= 1'b0;
            rsp_timeout_reg  <= 1'b0;
            mosi_reg.awid    <= AXI_ID;
            mosi_reg.awaddr  <= cmd_addr_i;
            mosi_reg.awlen   <= 8'd0;
            mosi_reg.awsize  <= AXI_SIZE_4B;
            mosi_reg.awburst <= AXI_BURST_INCR;
            mosi_reg.wdata   <= cmd_wdata_i;
            mosi_reg.wstrb   <= cmd_wstrb_i;
            mosi_reg.wlast   <= 1'b1;
            mosi_reg.arid    <= AXI_ID;
            mosi_reg.araddr  <= cmd_addr_i;
            mosi_reg.arlen   <= 8'd0;
            mosi_reg.arsize  <= AXI_SIZE_4B;
            mosi_reg.arburst <= AXI_BURST_INCR;
            if (cmd_write_i) begin
              mosi_reg.awvalid <= 1'b1;
              mosi_reg.wvalid  <= 1'b1;
              state_reg        <= WR_REQ;
            end else begin
              mosi_reg.arvalid <= 1'b1;
              state_reg        <= RD_REQ;
            end
          end else begin
            cmd_ready_reg <= 1'b1;
          end
        end

        WR_REQ: begin
          wdog_reg <= wdog_reg + 16'd1;
          if (aw_hs) begin
            mosi_reg.awvalid <= 1'b0;
            aw_sent_reg      <= 1'b1;
          end
          if (w_hs) begin
            mosi_reg.wvalid <= 1'b0;
            w_sent_reg      <= 1'b1;
          end
          // Completion is tested before the watchdog so it wins a tie.
          if (aw_done && w_done) begin
            mosi_reg.bready <= 1'b1;
            state_reg       <= WR_RESP;
          end else if (wdog_expired) begin
            mosi_reg.awvalid <= 1'b0;
            mosi_reg.wvalid  <= 1'b0;
            rsp_valid_reg    <= 1'b1;
            rsp_err_reg      <= 1'b1;
            rsp_timeout_reg  <= 1'b1;
            rsp_rdata_reg    <= '0;
            state_reg        <= RSP;
          end
        end

        WR_RESP: begin
          wdog_reg <= wdog_reg + 16'd1;
          if (b_hs) begin
            mosi_reg.bready <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_err_reg     <= b_err;
            rsp_rdata_reg   <= '0;
            state_reg       <= RSP;
          end else if (wdog_expired) begin
            mosi_reg.bready <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_err_reg     <= 1'b1;
            rsp_timeout_reg <= 1'b1;
            rsp_rdata_reg   <= '0;
            state_reg       <= RSP;
          end
        end

        RD_REQ: begin
          wdog_reg <= wdog_reg + 16'd1;
          if (ar_hs) begin
            mosi_reg.arvalid <= 1'b0;
            mosi_reg.rready  <= 1'b1;
            state_reg        <= RD_RESP;
          end else if (wdog_expired) begin
            mosi_reg.arvalid <= 1'b0;
            rsp_valid_reg    <= 1'b1;
            rsp_err_reg      <= 1'b1;
            rsp_timeout_reg  <= 1'b1;
            rsp_rdata_reg    <= '0;
            state_reg        <= RSP;
          end
        end

        RD_RESP: begin
          wdog_reg <= wdog_reg + 16'd1;
          if (r_hs) begin
            mosi_reg.rready <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_err_reg     <= r_err;
            rsp_rdata_reg   <= r_err ? 32'd0 : axi_miso.rdata;
            state_reg       <= RSP;
          end else if (wdog_expired) begin
            mosi_reg.rready <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_err_reg     <= 1'b1;
            rsp_timeout_reg <= 1'b1;
            rsp_rdata_reg   <= '0;
            state_reg       <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_reg;
  assign busy_o        = busy_reg;
  assign rsp_valid_o   = rsp_valid_reg;
  assign rsp_rdata_o   = rsp_rdata_reg;
  assign rsp_err_o     = rsp_err_reg;
  assign rsp_timeout_o = rsp_timeout_reg;
  assign axi_mosi      = mosi_reg;

endmodule
